// File: rtl/inst_decode_queue.sv
// Decode stage: buffers fetched instructions in a circular FIFO, decodes the head
// entry and presents a registered decode bundle to issue under valid/ready.
package inst_decode_pkg;
    typedef enum logic [2:0] {I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE} immType_e;

    typedef enum logic [5:0] {
        NOP, LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        MUL, MULH, MULHSU, MULHU,
        FADD, FSUB, FLW, FSW,
        CSRRS
    } opcodeType_e;
endpackage

module inst_decode_queue
    import inst_decode_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit EN_M     = 1'b1,
    parameter bit EN_F     = 1'b0,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [31:0]                if_inst,
    input  logic [31:0]                if_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [31:0]                id_pc,
    output logic [31:0]                id_inst,
    output logic [4:0]                 id_rs1,
    output logic [4:0]                 id_rs2,
    output logic [4:0]                 id_rd,
    output logic [11:0]                id_csr_addr,
    output logic [31:0]                id_imm,
    output immType_e                   id_imm_type,
    output opcodeType_e                id_opcode_type,
    output logic                       id_illegal,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    logic [31:0]   head_inst;
    logic [31:0]   head_pc;
    logic [6:0]    opc;
    logic [2:0]    f3;
    logic [6:0]    f7;
    opcodeType_e   dec_op;
    immType_e      dec_imm_type;
    logic [31:0]   dec_imm;

    assign if_ready  = (count != FULL);
    assign occupancy = count;
    assign push      = if_valid && if_ready;
    assign pop       = (count != '0) && (!id_valid || id_ready);

    assign head_inst = inst_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];
    assign opc       = head_inst[6:0];
    assign f3        = head_inst[14:12];
    assign f7        = head_inst[31:25];

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= if_inst;
            pc_mem[wr_ptr]   <= if_pc;
        end
    end

    // Flush outranks push and pop alike: a same-cycle push is simply lost.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        dec_imm_type = I_TYPE;
        case (opc)
            OPC_STORE:          dec_imm_type = S_TYPE;
            OPC_BRANCH:         dec_imm_type = B_TYPE;
            OPC_LUI, OPC_AUIPC: dec_imm_type = U_TYPE;
            OPC_JAL:            dec_imm_type = J_TYPE;
            default:            ;
        endcase
    end

    always_comb begin
        dec_imm = {{20{head_inst[31]}}, head_inst[31:20]};
        case (dec_imm_type)
            S_TYPE: dec_imm = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
            B_TYPE: dec_imm = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                               head_inst[30:25], head_inst[11:8], 1'b0};
            U_TYPE: dec_imm = {head_inst[31:12], 12'b0};
            J_TYPE: dec_imm = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                               head_inst[20], head_inst[30:21], 1'b0};
            default: ;
        endcase
    end

    // Anything left at NOP here had no legal encoding and is flagged illegal.
    always_comb begin
        dec_op = NOP;
        case (opc)
            OPC_LUI:   dec_op = LUI;
            OPC_AUIPC: dec_op = AUIPC;
            OPC_JAL:   dec_op = JAL;
            OPC_JALR:  if (f3 == 3'b000) dec_op = JALR;
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  dec_op = BEQ;
                    3'b001:  dec_op = BNE;
                    3'b100:  dec_op = BLT;
                    3'b101:  dec_op = BGE;
                    3'b110:  dec_op = BLTU;
                    3'b111:  dec_op = BGEU;
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                case (f3)
                    3'b000:  dec_op = LB;
                    3'b001:  dec_op = LH;
                    3'b010:  dec_op = LW;
                    3'b100:  dec_op = LBU;
                    3'b101:  dec_op = LHU;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                case (f3)
                    3'b000:  dec_op = SB;
                    3'b001:  dec_op = SH;
                    3'b010:  dec_op = SW;
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                case (f3)
                    3'b000:  dec_op = ADDI;
                    3'b010:  dec_op = SLTI;
                    3'b011:  dec_op = SLTIU;
                    3'b100:  dec_op = XORI;
                    3'b110:  dec_op = ORI;
                    3'b111:  dec_op = ANDI;
                    3'b001:  if (f7 == 7'b0000000) dec_op = SLLI;
                    3'b101: begin
                        if (f7 == 7'b0000000)      dec_op = SRLI;
                        else if (f7 == 7'b0100000) dec_op = SRAI;
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  dec_op = ADD;
                        3'b001:  dec_op = SLL;
                        3'b010:  dec_op = SLT;
                        3'b011:  dec_op = SLTU;
                        3'b100:  dec_op = XOR;
                        3'b101:  dec_op = SRL;
                        3'b110:  dec_op = OR;
                        3'b111:  dec_op = AND;
                        default: ;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000)      dec_op = SUB;
                    else if (f3 == 3'b101) dec_op = SRA;
                end else if (f7 == 7'b0000001 && EN_M) begin
                    case (f3)
                        3'b000:  dec_op = MUL;
                        3'b001:  dec_op = MULH;
                        3'b010:  dec_op = MULHSU;
                        3'b011:  dec_op = MULHU;
                        default: ;
                    endcase
                end
            end
            OPC_OP_FP: begin
                if (EN_F) begin
                    if (f7[6:2] == 5'b00000)      dec_op = FADD;
                    else if (f7[6:2] == 5'b00001) dec_op = FSUB;
                end
            end
            OPC_LOAD_FP:  if (EN_F && f3 == 3'b010) dec_op = FLW;
            OPC_STORE_FP: if (EN_F && f3 == 3'b010) dec_op = FSW;
            OPC_SYSTEM:   if (EN_ZICSR && f3 == 3'b010) dec_op = CSRRS;
            default: ;
        endcase
    end

    // Data registers only change on a load, so they stay frozen under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_inst        <= '0;
            id_rs1         <= '0;
            id_rs2         <= '0;
            id_rd          <= '0;
            id_csr_addr    <= '0;
            id_imm         <= '0;
            id_imm_type    <= I_TYPE;
            id_opcode_type <= NOP;
            id_illegal     <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (pop) begin
            id_valid       <= 1'b1;
            id_pc          <= head_pc;
            id_inst        <= head_inst;
            id_rs1         <= head_inst[19:15];
            id_rs2         <= head_inst[24:20];
            id_rd          <= head_inst[11:7];
            id_csr_addr    <= EN_ZICSR ? head_inst[31:20] : 12'h000;
            id_imm         <= dec_imm;
            id_imm_type    <= dec_imm_type;
            id_opcode_type <= dec_op;
            id_illegal     <= (dec_op == NOP);
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_inst_decode_queue.sv
// Self-checking bench for inst_decode_queue: directed scenarios plus randomized
// traffic compared against a queue-based model and a mask/match decode table.
module tb_inst_decode_queue;
    import inst_decode_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] csr;
        logic [31:0] imm;
        immType_e    it;
        opcodeType_e op;
        logic        ill;
    } bundle_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        opcodeType_e op;
        int          ext;
    } pat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = '0;
    logic [31:0] if_pc = '0;
    logic        id_ready = 1'b0;

    logic        a_if_ready, a_valid, a_ill;
    logic [31:0] a_pc, a_inst, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [11:0] a_csr;
    immType_e    a_it;
    opcodeType_e a_op;
    logic [2:0]  a_occ;

    logic        b_if_ready, b_valid, b_ill;
    logic [31:0] b_pc, b_inst, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [11:0] b_csr;
    immType_e    b_it;
    opcodeType_e b_op;
    logic [2:0]  b_occ;

    int checks_total = 0;
    int checks_passed = 0;

    entry_t m_q[$];
    entry_t m_pres;
    bit     m_pv = 1'b0;
    pat_t   pats[$];

    always #5 clk = ~clk;

    inst_decode_queue #(.DEPTH(DEPTH), .EN_M(1'b1), .EN_F(1'b0), .EN_ZICSR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_valid(if_valid), .if_ready(a_if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .id_valid(a_valid), .id_ready(id_ready), .id_pc(a_pc), .id_inst(a_inst),
        .id_rs1(a_rs1), .id_rs2(a_rs2), .id_rd(a_rd), .id_csr_addr(a_csr),
        .id_imm(a_imm), .id_imm_type(a_it), .id_opcode_type(a_op),
        .id_illegal(a_ill), .occupancy(a_occ)
    );

    inst_decode_queue #(.DEPTH(DEPTH), .EN_M(1'b0), .EN_F(1'b1), .EN_ZICSR(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_valid(if_valid), .if_ready(b_if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .id_valid(b_valid), .id_ready(id_ready), .id_pc(b_pc), .id_inst(b_inst),
        .id_rs1(b_rs1), .id_rs2(b_rs2), .id_rd(b_rd), .id_csr_addr(b_csr),
        .id_imm(b_imm), .id_imm_type(b_it), .id_opcode_type(b_op),
        .id_illegal(b_ill), .occupancy(b_occ)
    );

    task automatic add_pat(input logic [31:0] mask, input logic [31:0] match,
                           input opcodeType_e op, input int ext);
        pat_t p;
        p.mask = mask; p.match = match; p.op = op; p.ext = ext;
        pats.push_back(p);
    endtask

    // ext: 0 base, 1 M, 2 F, 3 Zicsr
    task automatic init_pats();
        add_pat(32'h0000007f, 32'h00000037, LUI, 0);
        add_pat(32'h0000007f, 32'h00000017, AUIPC, 0);
        add_pat(32'h0000007f, 32'h0000006f, JAL, 0);
        add_pat(32'h0000707f, 32'h00000067, JALR, 0);
        add_pat(32'h0000707f, 32'h00000063, BEQ, 0);
        add_pat(32'h0000707f, 32'h00001063, BNE, 0);
        add_pat(32'h0000707f, 32'h00004063, BLT, 0);
        add_pat(32'h0000707f, 32'h00005063, BGE, 0);
        add_pat(32'h0000707f, 32'h00006063, BLTU, 0);
        add_pat(32'h0000707f, 32'h00007063, BGEU, 0);
        add_pat(32'h0000707f, 32'h00000003, LB, 0);
        add_pat(32'h0000707f, 32'h00001003, LH, 0);
        add_pat(32'h0000707f, 32'h00002003, LW, 0);
        add_pat(32'h0000707f, 32'h00004003, LBU, 0);
        add_pat(32'h0000707f, 32'h00005003, LHU, 0);
        add_pat(32'h0000707f, 32'h00000023, SB, 0);
        add_pat(32'h0000707f, 32'h00001023, SH, 0);
        add_pat(32'h0000707f, 32'h00002023, SW, 0);
        add_pat(32'h0000707f, 32'h00000013, ADDI, 0);
        add_pat(32'h0000707f, 32'h00002013, SLTI, 0);
        add_pat(32'h0000707f, 32'h00003013, SLTIU, 0);
        add_pat(32'h0000707f, 32'h00004013, XORI, 0);
        add_pat(32'h0000707f, 32'h00006013, ORI, 0);
        add_pat(32'h0000707f, 32'h00007013, ANDI, 0);
        add_pat(32'hfe00707f, 32'h00001013, SLLI, 0);
        add_pat(32'hfe00707f, 32'h00005013, SRLI, 0);
        add_pat(32'hfe00707f, 32'h40005013, SRAI, 0);
        add_pat(32'hfe00707f, 32'h00000033, ADD, 0);
        add_pat(32'hfe00707f, 32'h40000033, SUB, 0);
        add_pat(32'hfe00707f, 32'h00001033, SLL, 0);
        add_pat(32'hfe00707f, 32'h00002033, SLT, 0);
        add_pat(32'hfe00707f, 32'h00003033, SLTU, 0);
        add_pat(32'hfe00707f, 32'h00004033, XOR, 0);
        add_pat(32'hfe00707f, 32'h00005033, SRL, 0);
        add_pat(32'hfe00707f, 32'h40005033, SRA, 0);
        add_pat(32'hfe00707f, 32'h00006033, OR, 0);
        add_pat(32'hfe00707f, 32'h00007033, AND, 0);
        add_pat(32'hfe00707f, 32'h02000033, MUL, 1);
        add_pat(32'hfe00707f, 32'h02001033, MULH, 1);
        add_pat(32'hfe00707f, 32'h02002033, MULHSU, 1);
        add_pat(32'hfe00707f, 32'h02003033, MULHU, 1);
        add_pat(32'hf800007f, 32'h00000053, FADD, 2);
        add_pat(32'hf800007f, 32'h08000053, FSUB, 2);
        add_pat(32'h0000707f, 32'h00002007, FLW, 2);
        add_pat(32'h0000707f, 32'h00002027, FSW, 2);
        add_pat(32'h0000707f, 32'h00002073, CSRRS, 3);
    endtask

    function automatic opcodeType_e ref_op(input logic [31:0] w, input bit em,
                                           input bit ef, input bit ez);
        opcodeType_e r = NOP;
        foreach (pats[i]) begin
            if ((w & pats[i].mask) == pats[i].match) begin
                if (pats[i].ext == 0 || (pats[i].ext == 1 && em) ||
                    (pats[i].ext == 2 && ef) || (pats[i].ext == 3 && ez))
                    r = pats[i].op;
            end
        end
        return r;
    endfunction

    function automatic immType_e ref_imm_type(input logic [31:0] w);
        logic [6:0] o = w[6:0];
        if (o == 7'h23) return S_TYPE;
        if (o == 7'h63) return B_TYPE;
        if (o == 7'h37 || o == 7'h17) return U_TYPE;
        if (o == 7'h6f) return J_TYPE;
        return I_TYPE;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        int v;
        case (ref_imm_type(w))
            S_TYPE: begin i12 = {w[31:25], w[11:7]}; v = i12; end
            B_TYPE: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; v = b13; end
            U_TYPE: v = w & 32'hfffff000;
            J_TYPE: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; v = j21; end
            default: begin i12 = w[31:20]; v = i12; end
        endcase
        return v;
    endfunction

    function automatic bundle_t expect_bundle(input bit em, input bit ef, input bit ez);
        bundle_t r = '0;
        if (m_pv) begin
            r.v    = 1'b1;
            r.pc   = m_pres.pc;
            r.inst = m_pres.inst;
            r.rs1  = m_pres.inst[19:15];
            r.rs2  = m_pres.inst[24:20];
            r.rd   = m_pres.inst[11:7];
            r.csr  = ez ? m_pres.inst[31:20] : 12'h000;
            r.imm  = ref_imm(m_pres.inst);
            r.it   = ref_imm_type(m_pres.inst);
            r.op   = ref_op(m_pres.inst, em, ef, ez);
            r.ill  = (r.op == NOP);
        end
        return r;
    endfunction

    function automatic bundle_t observe_a();
        bundle_t r = '0;
        if (a_valid) begin
            r.v = 1'b1; r.pc = a_pc; r.inst = a_inst; r.rs1 = a_rs1; r.rs2 = a_rs2;
            r.rd = a_rd; r.csr = a_csr; r.imm = a_imm; r.it = a_it; r.op = a_op; r.ill = a_ill;
        end
        return r;
    endfunction

    function automatic bundle_t observe_b();
        bundle_t r = '0;
        if (b_valid) begin
            r.v = 1'b1; r.pc = b_pc; r.inst = b_inst; r.rs1 = b_rs1; r.rs2 = b_rs2;
            r.rd = b_rd; r.csr = b_csr; r.imm = b_imm; r.it = b_it; r.op = b_op; r.ill = b_ill;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 13))
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6f;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h03;
            6:  w[6:0] = 7'h23;
            7:  w[6:0] = 7'h13;
            8:  w[6:0] = 7'h33;
            9:  w[6:0] = 7'h53;
            10: w[6:0] = 7'h07;
            11: w[6:0] = 7'h27;
            12: w[6:0] = 7'h73;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: w[31:25] = 7'h04;
            endcase
        end
        return w;
    endfunction

    // Advances one clock and applies the observable queue rules to the model.
    task automatic step();
        bit     push;
        bit     load;
        entry_t e;
        push = if_valid && (m_q.size() != DEPTH);
        e.inst = if_inst;
        e.pc   = if_pc;
        if (!rst_n || flush) begin
            m_q.delete();
            m_pv = 1'b0;
        end else begin
            load = (m_q.size() != 0) && (!m_pv || id_ready);
            if (load) begin
                m_pres = m_q.pop_front();
                m_pv   = 1'b1;
            end else if (id_ready) begin
                m_pv = 1'b0;
            end
            if (push) m_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; if_valid = 1'b1; if_inst = 32'h00500093; id_ready = 1'b1;
        step();
        step();
        checks_total++;
        if ({a_valid, a_occ} !== 4'b0000)
            $display("[TB] FAIL reset_valid_occ: got %b expected 0000", {a_valid, a_occ});
        else checks_passed++;
        checks_total++;
        if ({a_pc, a_inst, a_rs1, a_rs2, a_rd, a_csr, a_imm, a_ill} !== '0)
            $display("[TB] FAIL reset_data: got pc=%h inst=%h imm=%h ill=%b expected all zero",
                     a_pc, a_inst, a_imm, a_ill);
        else checks_passed++;
        checks_total++;
        if (a_op !== NOP || a_it !== I_TYPE)
            $display("[TB] FAIL reset_types: got op=%0d it=%0d expected op=%0d it=%0d",
                     a_op, a_it, NOP, I_TYPE);
        else checks_passed++;
        checks_total++;
        if (a_if_ready !== 1'b1)
            $display("[TB] FAIL reset_if_ready: got %b expected 1", a_if_ready);
        else checks_passed++;
        rst_n = 1'b1; if_valid = 1'b0;
    endtask

    task automatic test_addi();
        do_reset();
        id_ready = 1'b1;
        if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'h00000100;
        step();
        if_valid = 1'b0;
        checks_total++;
        if (a_valid !== 1'b0)
            $display("[TB] FAIL addi_latency: got valid %b expected 0", a_valid);
        else checks_passed++;
        step();
        checks_total++;
        if ({a_valid, a_rd, a_rs1, a_imm, a_pc, a_ill} !== {1'b1, 5'd1, 5'd0, 32'h5, 32'h100, 1'b0})
            $display("[TB] FAIL addi_fields: got v=%b rd=%0d rs1=%0d imm=%h pc=%h ill=%b expected v=1 rd=1 rs1=0 imm=5 pc=100 ill=0",
                     a_valid, a_rd, a_rs1, a_imm, a_pc, a_ill);
        else checks_passed++;
        checks_total++;
        if (a_op !== ADDI)
            $display("[TB] FAIL addi_op: got %0d expected %0d", a_op, ADDI);
        else checks_passed++;
    endtask

    task automatic test_imm_signs();
        do_reset();
        id_ready = 1'b1;
        if_valid = 1'b1; if_inst = 32'hFE000EE3; if_pc = 32'h00000200;
        step();
        if_inst = 32'h800000EF; if_pc = 32'h00000204;
        step();
        if_valid = 1'b0;
        checks_total++;
        if ({a_valid, a_it, a_imm} !== {1'b1, B_TYPE, 32'hFFFFFFFC})
            $display("[TB] FAIL beq_imm: got v=%b it=%0d imm=%h expected v=1 it=%0d imm=fffffffc",
                     a_valid, a_it, a_imm, B_TYPE);
        else checks_passed++;
        step();
        checks_total++;
        if ({a_valid, a_it, a_imm, a_op} !== {1'b1, J_TYPE, 32'hFFF00000, JAL})
            $display("[TB] FAIL jal_imm: got v=%b it=%0d imm=%h op=%0d expected v=1 it=%0d imm=fff00000 op=%0d",
                     a_valid, a_it, a_imm, a_op, J_TYPE, JAL);
        else checks_passed++;
    endtask

    task automatic test_gating();
        do_reset();
        id_ready = 1'b1;
        if_valid = 1'b1; if_inst = 32'h022081B3; if_pc = 32'h00000300;
        step();
        if_valid = 1'b0;
        step();
        checks_total++;
        if ({b_valid, b_op, b_ill} !== {1'b1, NOP, 1'b1})
            $display("[TB] FAIL mul_no_m: got v=%b op=%0d ill=%b expected v=1 op=%0d ill=1",
                     b_valid, b_op, b_ill, NOP);
        else checks_passed++;
        checks_total++;
        if ({a_valid, a_op, a_ill} !== {1'b1, MUL, 1'b0})
            $display("[TB] FAIL mul_with_m: got v=%b op=%0d ill=%b expected v=1 op=%0d ill=0",
                     a_valid, a_op, a_ill, MUL);
        else checks_passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] bp_inst [6];
        int accepted = 0;
        bit ok;
        bundle_t exp_b;
        for (int i = 0; i < 6; i++) bp_inst[i] = rand_inst();
        do_reset();
        id_ready = 1'b0;
        for (int c = 0; c < 20 && accepted < 5; c++) begin
            if_valid = 1'b1;
            if_inst  = bp_inst[accepted];
            if_pc    = 32'h200 + 32'(4 * accepted);
            ok = (m_q.size() != DEPTH);
            step();
            if (ok) accepted++;
        end
        checks_total++;
        if (accepted !== 5)
            $display("[TB] FAIL bp_fill_timeout: got %0d accepted expected 5", accepted);
        else checks_passed++;
        if_inst = bp_inst[5];
        if_pc   = 32'h214;
        checks_total++;
        if ({a_if_ready, a_occ, a_valid, a_pc} !== {1'b0, 3'd4, 1'b1, 32'h200})
            $display("[TB] FAIL bp_full: got rdy=%b occ=%0d v=%b pc=%h expected rdy=0 occ=4 v=1 pc=200",
                     a_if_ready, a_occ, a_valid, a_pc);
        else checks_passed++;
        step();
        if_valid = 1'b0;
        checks_total++;
        if (a_occ !== 3'd4)
            $display("[TB] FAIL bp_refused: got occ=%0d expected 4", a_occ);
        else checks_passed++;
        id_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            exp_b = expect_bundle(1'b1, 1'b0, 1'b1);
            checks_total++;
            if (observe_a() !== exp_b || a_pc !== 32'h200 + 32'(4 * j))
                $display("[TB] FAIL bp_drain%0d: got pc=%h v=%b expected pc=%h v=1",
                         j, a_pc, a_valid, 32'h200 + 32'(4 * j));
            else checks_passed++;
            step();
        end
        checks_total++;
        if (a_valid !== 1'b0)
            $display("[TB] FAIL bp_empty: got valid %b expected 0", a_valid);
        else checks_passed++;
    endtask

    task automatic test_flush();
        do_reset();
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1; if_inst = rand_inst(); if_pc = 32'h400 + 32'(4 * i);
            step();
        end
        checks_total++;
        if ({a_occ, a_valid} !== {3'd3, 1'b1})
            $display("[TB] FAIL flush_setup: got occ=%0d v=%b expected occ=3 v=1", a_occ, a_valid);
        else checks_passed++;
        flush = 1'b1; if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'hDEAD0000;
        #1;
        checks_total++;
        if (a_if_ready !== 1'b1)
            $display("[TB] FAIL flush_if_ready: got %b expected 1", a_if_ready);
        else checks_passed++;
        step();
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
        checks_total++;
        if ({a_occ, a_valid} !== {3'd0, 1'b0})
            $display("[TB] FAIL flush_clear: got occ=%0d v=%b expected occ=0 v=0", a_occ, a_valid);
        else checks_passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks_total++;
            if (a_valid !== 1'b0 || a_pc === 32'hDEAD0000)
                $display("[TB] FAIL flush_dropped: got v=%b pc=%h expected v=0", a_valid, a_pc);
            else checks_passed++;
        end
    endtask

    task automatic test_back_to_back();
        int emitted = 0;
        bundle_t exp_b;
        do_reset();
        id_ready = 1'b1;
        for (int c = 0; c < 24 && emitted < 16; c++) begin
            if (c < 16) begin
                if_valid = 1'b1; if_inst = rand_inst(); if_pc = 32'h1000 + 32'(4 * c);
            end else begin
                if_valid = 1'b0;
            end
            step();
            exp_b = expect_bundle(1'b1, 1'b0, 1'b1);
            checks_total++;
            if (observe_a() !== exp_b)
                $display("[TB] FAIL stream_bundle: got %h expected %h", observe_a(), exp_b);
            else checks_passed++;
            if (a_valid === 1'b1) begin
                checks_total++;
                if (a_pc !== 32'h1000 + 32'(4 * emitted))
                    $display("[TB] FAIL stream_order: got pc=%h expected %h",
                             a_pc, 32'h1000 + 32'(4 * emitted));
                else checks_passed++;
                emitted++;
            end
        end
        if_valid = 1'b0;
        checks_total++;
        if (emitted !== 16)
            $display("[TB] FAIL stream_count: got %0d expected 16", emitted);
        else checks_passed++;
    endtask

    task automatic test_random();
        bundle_t exp_b;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst_n    = ($urandom_range(0, 99) >= 2);
            flush    = ($urandom_range(0, 99) < 5);
            if_valid = ($urandom_range(0, 99) < 70);
            id_ready = ($urandom_range(0, 99) < 60);
            if_inst  = rand_inst();
            if_pc    = $urandom;
            step();
            exp_b = expect_bundle(1'b1, 1'b0, 1'b1);
            checks_total++;
            if (observe_a() !== exp_b)
                $display("[TB] FAIL rand_a_bundle: got %h expected %h", observe_a(), exp_b);
            else checks_passed++;
            exp_b = expect_bundle(1'b0, 1'b1, 1'b0);
            checks_total++;
            if (observe_b() !== exp_b)
                $display("[TB] FAIL rand_b_bundle: got %h expected %h", observe_b(), exp_b);
            else checks_passed++;
            checks_total++;
            if (a_occ !== 3'(m_q.size()) || a_if_ready !== (m_q.size() != DEPTH))
                $display("[TB] FAIL rand_occ: got occ=%0d rdy=%b expected occ=%0d", a_occ,
                         a_if_ready, m_q.size());
            else checks_passed++;
        end
        rst_n = 1'b1; flush = 1'b0; if_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        init_pats();
        test_reset();
        test_addi();
        test_imm_signs();
        test_gating();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
